// File: rtl/rr_lock_arbiter.sv
// ============================================================================
//  Module      : rr_lock_arbiter
//  Description : Round-robin arbiter that locks the shared resource to one
//                requester until it releases it. The optional forced-release
//                watchdog is built when RR_LOCK_ARBITER_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_lock_arbiter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 64,
   parameter int IDX_W   = ($clog2(N) > 0) ? $clog2(N) : 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [N-1:0]     iReq,
   input  logic             iDone,
   output logic [N-1:0]     oGnt,
   output logic [IDX_W-1:0] oGntIdx,
   output logic             oBusy,
   output logic             oTimeout
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_gnt;
   logic [IDX_W-1:0] r_gnt_idx;
   logic [IDX_W-1:0] r_ptr;

   logic             w_any;
   logic             w_force;
   logic             w_release;
   logic [IDX_W-1:0] w_next_ptr;
   logic [IDX_W-1:0] w_sel_ptr;
   logic [IDX_W-1:0] w_win;
   logic [N-1:0]     w_win_oh;

   generate
      if (N < 1 || TIMEOUT < 2) begin : g_param_check
         $error("rr_lock_arbiter: N must be >= 1 and TIMEOUT >= 2");
      end
   endgenerate

   assign w_any      = |iReq;
   assign w_release  = (r_state == S_BUSY) && (iDone || w_force);
   assign w_next_ptr = (r_gnt_idx == IDX_W'(N - 1)) ? '0 : r_gnt_idx + 1'b1;
   // On a release the next winner is chosen against the already-advanced pointer.
   assign w_sel_ptr  = w_release ? w_next_ptr : r_ptr;

   always_comb begin
      w_win = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (iReq[k]) w_win = IDX_W'(k);
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (iReq[k] && (k >= int'(w_sel_ptr))) w_win = IDX_W'(k);
      end
   end

   always_comb begin
      w_win_oh        = '0;
      w_win_oh[w_win] = 1'b1;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_ptr     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state   <= S_BUSY;
                  r_gnt     <= w_win_oh;
                  r_gnt_idx <= w_win;
               end
            end
            S_BUSY: begin
               if (w_release) begin
                  r_ptr <= w_next_ptr;
                  if (w_any) begin
                     r_gnt     <= w_win_oh;
                     r_gnt_idx <= w_win;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= '0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   // iDone on the expiry cycle wins, so no timeout is reported then.
   assign w_force = (r_state == S_BUSY) && !iDone && (r_cnt == c_CNT_MAX);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_force;
         if (w_any && ((r_state == S_IDLE) || w_release)) begin
            r_cnt <= '0;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign oTimeout = r_timeout;
`else
   assign w_force  = 1'b0;
   assign oTimeout = 1'b0;
`endif

   assign oGnt    = r_gnt;
   assign oGntIdx = r_gnt_idx;
   assign oBusy   = |r_gnt;

endmodule

`default_nettype wire
